eep_resp: RTL and testbench

Behavioral and synthesizable responder for the calibration EEPROM port driven by the digital core. It sits on the far side of the `eep_cs_n` / `eep_r_w_n` / `eep_addr` / `chrg_pmp_en` interface and holds four 14-bit words. It serves reads with one-cycle latency and commits a write only after the charge pump has been held for a programmed number of cycles. It is used as the EEPROM stand-in for full-chip simulation and as the FPGA-prototype EEPROM.

---
 rtl/eep_resp.sv | 149 ++++++++++++++
 tb/tb_eep_resp.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/eep_resp.sv
// eep_resp: calibration EEPROM responder holding four 14-bit words.
// Reads complete in one cycle from IDLE. A write is committed only after
// the charge pump has been held high for PUMP_CYC consecutive cycles.
module eep_resp #(
    parameter int unsigned PUMP_CYC = 3,
    parameter int unsigned TMO_CYC  = 8,
    parameter logic [13:0] INIT0    = 14'h0000,
    parameter logic [13:0] INIT1    = 14'h0000,
    parameter logic [13:0] INIT2    = 14'h0000,
    parameter logic [13:0] INIT3    = 14'h0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        eep_cs_n,
    input  logic        eep_r_w_n,
    input  logic [1:0]  eep_addr,
    input  logic [13:0] eep_wr_data,
    input  logic        chrg_pmp_en,
    output logic [13:0] eep_rd_data,
    output logic        busy,
    output logic        wr_done,
    output logic        wr_err
);

    localparam int unsigned PW = $clog2(PUMP_CYC + 1);
    localparam int unsigned TW = $clog2(TMO_CYC + 1);

    localparam logic [PW-1:0] PCNT_LAST = PW'(PUMP_CYC - 1);
    localparam logic [PW-1:0] PCNT_MAX  = '1;
    localparam logic [TW-1:0] TCNT_LAST = TW'(TMO_CYC - 1);
    localparam logic [TW-1:0] TCNT_MAX  = '1;

    typedef enum logic [1:0] {
        IDLE,
        PUMP,
        COMMIT,
        REL
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [PW-1:0] pcnt;
    logic [PW-1:0] pcnt_nxt;
    logic [TW-1:0] tcnt;
    logic [TW-1:0] tcnt_nxt;
    logic [1:0]    wa;
    logic [13:0]   wd;
    logic          latch_req;
    logic          err_nxt;
    logic [13:0]   mem [4];

    // Next-state logic: write request, pump counting, timeout and aborts
    always_comb begin
        state_nxt = state;
        pcnt_nxt  = pcnt;
        tcnt_nxt  = tcnt;
        latch_req = 1'b0;
        err_nxt   = 1'b0;
        case (state)
            IDLE: begin
                if (!eep_cs_n && !eep_r_w_n) begin
                    latch_req = 1'b1;
                    pcnt_nxt  = '0;
                    tcnt_nxt  = '0;
                    state_nxt = PUMP;
                end
            end
            PUMP: begin
                if (eep_cs_n || eep_r_w_n) begin
                    err_nxt   = 1'b1;
                    state_nxt = REL;
                end else if (chrg_pmp_en) begin
                    if (pcnt != PCNT_MAX) begin
                        pcnt_nxt = pcnt + PW'(1);
                    end
                    if (pcnt == PCNT_LAST) begin
                        state_nxt = COMMIT;
                    end
                end else if (pcnt != '0) begin
                    err_nxt   = 1'b1;
                    state_nxt = REL;
                end else begin
                    if (tcnt != TCNT_MAX) begin
                        tcnt_nxt = tcnt + TW'(1);
                    end
                    if (tcnt == TCNT_LAST) begin
                        err_nxt   = 1'b1;
                        state_nxt = REL;
                    end
                end
            end
            COMMIT: begin
                state_nxt = REL;
            end
            REL: begin
                if (eep_cs_n) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Control registers: state, counters, latched request and status pulses
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            pcnt    <= '0;
            tcnt    <= '0;
            wa      <= '0;
            wd      <= '0;
            busy    <= 1'b0;
            wr_done <= 1'b0;
            wr_err  <= 1'b0;
        end else begin
            state   <= state_nxt;
            pcnt    <= pcnt_nxt;
            tcnt    <= tcnt_nxt;
            busy    <= (state_nxt != IDLE);
            wr_done <= (state_nxt == COMMIT);
            wr_err  <= err_nxt;
            if (latch_req) begin
                wa <= eep_addr;
                wd <= eep_wr_data;
            end
        end
    end

    // Storage array and registered read port; reads are served only from IDLE
    always_ff @(posedge clk) begin
        if (rst) begin
            mem[0]      <= INIT0;
            mem[1]      <= INIT1;
            mem[2]      <= INIT2;
            mem[3]      <= INIT3;
            eep_rd_data <= '0;
        end else begin
            if (state == COMMIT) begin
                mem[wa] <= wd;
            end
            if (state == IDLE && !eep_cs_n && eep_r_w_n) begin
                eep_rd_data <= mem[eep_addr];
            end
        end
    end

endmodule

// File: tb/tb_eep_resp.sv
// tb_eep_resp: directed bench for eep_resp with a transaction-level model
// checked every cycle, plus literal expectations at key points.
module tb_eep_resp;

    localparam int unsigned PUMP_CYC = 3;
    localparam int unsigned TMO_CYC  = 8;
    localparam logic [13:0] INIT0    = 14'h0123;
    localparam logic [13:0] INIT1    = 14'h0456;
    localparam logic [13:0] INIT2    = 14'h01A5;
    localparam logic [13:0] INIT3    = 14'h2BCD;

    logic        clk         = 1'b0;
    logic        rst         = 1'b1;
    logic        eep_cs_n    = 1'b1;
    logic        eep_r_w_n   = 1'b1;
    logic [1:0]  eep_addr    = 2'd0;
    logic [13:0] eep_wr_data = 14'd0;
    logic        chrg_pmp_en = 1'b0;
    logic [13:0] eep_rd_data;
    logic        busy;
    logic        wr_done;
    logic        wr_err;

    int n_checks = 0;
    int n_errors = 0;

    // Model state: an open transaction is either pumping, committing or releasing
    logic [13:0] m_mem [4];
    logic [13:0] exp_rd;
    bit          exp_busy;
    bit          exp_done;
    bit          exp_err;
    bit          model_valid = 1'b0;
    bit          m_active;
    bit          m_pumping;
    bit          m_commit;
    int          m_highs;
    int          m_waits;
    logic [1:0]  m_addr;
    logic [13:0] m_data;

    eep_resp #(
        .PUMP_CYC (PUMP_CYC),
        .TMO_CYC  (TMO_CYC),
        .INIT0    (INIT0),
        .INIT1    (INIT1),
        .INIT2    (INIT2),
        .INIT3    (INIT3)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .eep_cs_n    (eep_cs_n),
        .eep_r_w_n   (eep_r_w_n),
        .eep_addr    (eep_addr),
        .eep_wr_data (eep_wr_data),
        .chrg_pmp_en (chrg_pmp_en),
        .eep_rd_data (eep_rd_data),
        .busy        (busy),
        .wr_done     (wr_done),
        .wr_err      (wr_err)
    );

    // Free-running clock
    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [13:0] actual,
                                input logic [13:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    // Drive one cycle of inputs, then wait until the following falling edge
    task automatic apply_stimulus(input logic cs_n, input logic r_w_n, input logic [1:0] addr,
                                  input logic [13:0] data, input logic pmp);
        eep_cs_n    = cs_n;
        eep_r_w_n   = r_w_n;
        eep_addr    = addr;
        eep_wr_data = data;
        chrg_pmp_en = pmp;
        @(negedge clk);
    endtask

    task automatic idle_cycle();
        apply_stimulus(1'b1, 1'b1, 2'd0, 14'd0, 1'b0);
    endtask

    task automatic read_word(input logic [1:0] addr, input logic [13:0] expected, input string name);
        apply_stimulus(1'b0, 1'b1, addr, 14'd0, 1'b0);
        check_output(name, eep_rd_data, expected);
    endtask

    // Model step at each rising edge: transaction view of the responder
    task automatic model_step();
        bit done = 1'b0;
        bit err  = 1'b0;
        if (rst) begin
            m_mem     = '{INIT0, INIT1, INIT2, INIT3};
            exp_rd    = 14'd0;
            m_active  = 1'b0;
            m_pumping = 1'b0;
            m_commit  = 1'b0;
        end else if (!m_active) begin
            if (!eep_cs_n && eep_r_w_n) begin
                exp_rd = m_mem[eep_addr];
            end else if (!eep_cs_n && !eep_r_w_n) begin
                m_active  = 1'b1;
                m_pumping = 1'b1;
                m_addr    = eep_addr;
                m_data    = eep_wr_data;
                m_highs   = 0;
                m_waits   = 0;
            end
        end else if (m_commit) begin
            m_mem[m_addr] = m_data;
            m_commit      = 1'b0;
        end else if (m_pumping) begin
            if (eep_cs_n || eep_r_w_n) begin
                err       = 1'b1;
                m_pumping = 1'b0;
            end else if (chrg_pmp_en) begin
                m_highs++;
                if (m_highs == PUMP_CYC) begin
                    done      = 1'b1;
                    m_pumping = 1'b0;
                    m_commit  = 1'b1;
                end
            end else if (m_highs > 0) begin
                err       = 1'b1;
                m_pumping = 1'b0;
            end else begin
                m_waits++;
                if (m_waits == TMO_CYC) begin
                    err       = 1'b1;
                    m_pumping = 1'b0;
                end
            end
        end else if (eep_cs_n) begin
            m_active = 1'b0;
        end
        exp_busy    = m_active;
        exp_done    = done;
        exp_err     = err;
        model_valid = 1'b1;
    endtask

    initial begin
        forever begin
            @(posedge clk);
            model_step();
        end
    end

    // Per-cycle comparison of every output against the model
    initial begin
        forever begin
            @(negedge clk);
            if (model_valid) begin
                check_output("cyc_rd_data", eep_rd_data, exp_rd);
                check_output("cyc_busy", {13'd0, busy}, {13'd0, exp_busy});
                check_output("cyc_wr_done", {13'd0, wr_done}, {13'd0, exp_done});
                check_output("cyc_wr_err", {13'd0, wr_err}, {13'd0, exp_err});
            end
        end
    end

    initial begin
        // Reset state
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check_output("rst_rd_data", eep_rd_data, 14'd0);
        check_output("rst_busy", {13'd0, busy}, 14'd0);
        check_output("rst_wr_done", {13'd0, wr_done}, 14'd0);
        check_output("rst_wr_err", {13'd0, wr_err}, 14'd0);
        rst = 1'b0;
        idle_cycle();

        // Reads of reset contents, back to back
        read_word(2'd2, 14'h01A5, "read_init2");
        check_output("read_busy", {13'd0, busy}, 14'd0);
        read_word(2'd0, 14'h0123, "read_init0");
        read_word(2'd3, 14'h2BCD, "read_init3");
        idle_cycle();

        // Full write of 3FFF to word 1
        $display("[TB] write 3FFF to word 1");
        apply_stimulus(1'b0, 1'b0, 2'd1, 14'h3FFF, 1'b0);
        check_output("wr1_busy_c1", {13'd0, busy}, 14'd1);
        apply_stimulus(1'b0, 1'b0, 2'd1, 14'h3FFF, 1'b1);
        apply_stimulus(1'b0, 1'b0, 2'd1, 14'h3FFF, 1'b1);
        check_output("wr1_done_c3", {13'd0, wr_done}, 14'd0);
        apply_stimulus(1'b0, 1'b0, 2'd1, 14'h3FFF, 1'b1);
        check_output("wr1_done_c4", {13'd0, wr_done}, 14'd1);
        check_output("wr1_err_c4", {13'd0, wr_err}, 14'd0);
        apply_stimulus(1'b0, 1'b0, 2'd1, 14'h0000, 1'b0);
        check_output("wr1_done_c5", {13'd0, wr_done}, 14'd0);
        check_output("wr1_busy_rel", {13'd0, busy}, 14'd1);
        idle_cycle();
        check_output("wr1_busy_idle", {13'd0, busy}, 14'd0);
        read_word(2'd1, 14'h3FFF, "wr1_read1");
        read_word(2'd0, 14'h0123, "wr1_read0");
        read_word(2'd2, 14'h01A5, "wr1_read2");
        read_word(2'd3, 14'h2BCD, "wr1_read3");
        idle_cycle();

        // Pump dropped early on a write to word 3
        $display("[TB] pump dropped early");
        apply_stimulus(1'b0, 1'b0, 2'd3, 14'h1111, 1'b0);
        apply_stimulus(1'b0, 1'b0, 2'd3, 14'h1111, 1'b1);
        apply_stimulus(1'b0, 1'b0, 2'd3, 14'h1111, 1'b1);
        apply_stimulus(1'b0, 1'b0, 2'd3, 14'h1111, 1'b0);
        check_output("drop_err", {13'd0, wr_err}, 14'd1);
        check_output("drop_done", {13'd0, wr_done}, 14'd0);
        apply_stimulus(1'b0, 1'b0, 2'd3, 14'h1111, 1'b0);
        check_output("drop_err_once", {13'd0, wr_err}, 14'd0);
        check_output("drop_busy_held", {13'd0, busy}, 14'd1);
        apply_stimulus(1'b0, 1'b0, 2'd3, 14'h1111, 1'b0);
        check_output("drop_busy_held2", {13'd0, busy}, 14'd1);
        idle_cycle();
        check_output("drop_busy_free", {13'd0, busy}, 14'd0);
        read_word(2'd3, 14'h2BCD, "drop_read3");
        idle_cycle();

        // Pump never asserted: PUMP waits TMO_CYC cycles, abort pulse follows
        $display("[TB] pump timeout");
        apply_stimulus(1'b0, 1'b0, 2'd0, 14'h0AAA, 1'b0);
        for (int i = 0; i < TMO_CYC - 1; i++) begin
            apply_stimulus(1'b0, 1'b0, 2'd0, 14'h0AAA, 1'b0);
        end
        check_output("tmo_err_early", {13'd0, wr_err}, 14'd0);
        check_output("tmo_busy", {13'd0, busy}, 14'd1);
        apply_stimulus(1'b0, 1'b0, 2'd0, 14'h0AAA, 1'b0);
        check_output("tmo_err", {13'd0, wr_err}, 14'd1);
        idle_cycle();
        read_word(2'd0, 14'h0123, "tmo_read0");
        idle_cycle();

        // Pump rising late, still within the timeout
        $display("[TB] late pump");
        apply_stimulus(1'b0, 1'b0, 2'd0, 14'h0777, 1'b0);
        apply_stimulus(1'b0, 1'b0, 2'd0, 14'h0777, 1'b0);
        apply_stimulus(1'b0, 1'b0, 2'd0, 14'h0777, 1'b0);
        apply_stimulus(1'b0, 1'b0, 2'd0, 14'h0777, 1'b1);
        apply_stimulus(1'b0, 1'b0, 2'd0, 14'h0777, 1'b1);
        apply_stimulus(1'b0, 1'b0, 2'd0, 14'h0777, 1'b1);
        check_output("late_done", {13'd0, wr_done}, 14'd1);
        idle_cycle();
        idle_cycle();
        read_word(2'd0, 14'h0777, "late_read0");
        idle_cycle();

        // Address and data change during PUMP; latched values must commit
        $display("[TB] latched address and data");
        apply_stimulus(1'b0, 1'b0, 2'd2, 14'h2222, 1'b0);
        for (int i = 0; i < PUMP_CYC; i++) begin
            apply_stimulus(1'b0, 1'b0, 2'd0, 14'h3333, 1'b1);
        end
        check_output("latch_done", {13'd0, wr_done}, 14'd1);
        idle_cycle();
        idle_cycle();
        read_word(2'd2, 14'h2222, "latch_read2");
        read_word(2'd0, 14'h0777, "latch_read0");
        idle_cycle();

        // Direction flips to read during PUMP: abort, and no read is served
        $display("[TB] read during pump");
        apply_stimulus(1'b0, 1'b0, 2'd1, 14'h0555, 1'b0);
        apply_stimulus(1'b0, 1'b1, 2'd3, 14'h0000, 1'b0);
        check_output("rdab_err", {13'd0, wr_err}, 14'd1);
        check_output("rdab_rd_hold", eep_rd_data, 14'h0777);
        apply_stimulus(1'b0, 1'b1, 2'd3, 14'h0000, 1'b0);
        check_output("rdab_rd_hold2", eep_rd_data, 14'h0777);
        check_output("rdab_busy", {13'd0, busy}, 14'd1);
        idle_cycle();
        read_word(2'd1, 14'h3FFF, "rdab_read1");
        idle_cycle();

        // Reset in the middle of PUMP
        $display("[TB] reset mid-pump");
        apply_stimulus(1'b0, 1'b0, 2'd1, 14'h1234, 1'b0);
        apply_stimulus(1'b0, 1'b0, 2'd1, 14'h1234, 1'b1);
        rst = 1'b1;
        apply_stimulus(1'b0, 1'b0, 2'd1, 14'h1234, 1'b1);
        check_output("mrst_busy", {13'd0, busy}, 14'd0);
        check_output("mrst_done", {13'd0, wr_done}, 14'd0);
        check_output("mrst_err", {13'd0, wr_err}, 14'd0);
        check_output("mrst_rd", eep_rd_data, 14'd0);
        rst = 1'b0;
        idle_cycle();
        check_output("mrst_done_after", {13'd0, wr_done}, 14'd0);
        read_word(2'd1, 14'h0456, "mrst_read1");
        read_word(2'd2, 14'h01A5, "mrst_read2");
        read_word(2'd0, 14'h0123, "mrst_read0");
        idle_cycle();
        idle_cycle();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
